// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Issues one instruction-memory read
//                at a time for the current PC, captures the response (or a
//                fault) into the IF/ID register and pulses pc_step on accept.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] NOP_INSN = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc,
  output logic            pc_step,
  input  logic            flush,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            id_fault
);

  // REQ : ready to issue a read for pc
  // WAIT: one read outstanding, waiting for its response
  // DROP: outstanding read was killed by flush; swallow its response
  // HOLD: IF/ID holds an instruction for decode
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t          state;
  logic [XLEN-1:0] req_pc;
  logic            pc_aligned;

  assign pc_aligned = (pc[1:0] == 2'b00);

  // Request is combinational so the memory sees it in the same cycle as the PC;
  // it is gated by reset, flush and misalignment. The address is the live pc,
  // which cannot move until the accept pulses pc_step.
  always_comb begin
    imem_req_valid = rst_n && (state == S_REQ) && pc_aligned && !flush;
    imem_req_addr  = pc;
    pc_step        = imem_req_valid && imem_req_ready;
  end

  // Fetch state machine and IF/ID register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_REQ;
      req_pc   <= '0;
      id_valid <= 1'b0;
      id_fault <= 1'b0;
      id_instr <= NOP_INSN;
      id_pc    <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (!flush) begin
            if (!pc_aligned) begin
              // Misaligned PC: report a fault without touching memory.
              id_instr <= NOP_INSN;
              id_pc    <= pc;
              id_fault <= 1'b1;
              id_valid <= 1'b1;
              state    <= S_HOLD;
            end else if (imem_req_ready) begin
              req_pc <= pc;
              state  <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (flush) begin
              state <= S_REQ;
            end else begin
              id_instr <= imem_rsp_err ? NOP_INSN : imem_rsp_data;
              id_pc    <= req_pc;
              id_fault <= imem_rsp_err;
              id_valid <= 1'b1;
              state    <= S_HOLD;
            end
          end else if (flush) begin
            state <= S_DROP;
          end
        end
        S_DROP: begin
          if (imem_rsp_valid) begin
            state <= S_REQ;
          end
        end
        S_HOLD: begin
          // flush and id_ready both release the register; flush kills it.
          if (flush || id_ready) begin
            id_valid <= 1'b0;
            state    <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit: directed vector table,
//                hand-written reset sequence and randomized traffic checked
//                against a transaction-level model of the fetch stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc = 32'h100;
  logic        pc_step;
  logic        flush = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        imem_rsp_err = 1'b0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_fault;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.XLEN(32), .NOP_INSN(32'h00000013)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc             (pc),
    .pc_step        (pc_step),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_fault       (id_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        fl;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        re;
    logic        idr;
    logic        e_rv;
    logic        e_step;
    logic        e_idv;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_fault;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(logic [31:0] p, logic fl, logic rdy, logic rv,
                              logic [31:0] rd, logic re, logic idr,
                              logic erv, logic estep, logic eidv,
                              logic [31:0] einstr, logic [31:0] epc, logic efault);
    vec_t v;
    v.pc = p; v.fl = fl; v.rdy = rdy; v.rv = rv; v.rd = rd; v.re = re; v.idr = idr;
    v.e_rv = erv; v.e_step = estep; v.e_idv = eidv;
    v.e_instr = einstr; v.e_pc = epc; v.e_fault = efault;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] p, input logic fl, input logic rdy,
                       input logic rv, input logic [31:0] rd, input logic re,
                       input logic idr);
    pc = p; flush = fl; imem_req_ready = rdy;
    imem_rsp_valid = rv; imem_rsp_data = rd; imem_rsp_err = re; id_ready = idr;
  endtask

  // Memory contents and error map used by the random phase.
  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic mem_err(logic [31:0] a);
    return (a[5:2] == 4'hB);
  endfunction

  initial begin
    // ---------------- reset state ----------------
    #12;
    chk("reset_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("reset_pc_step", {31'b0, pc_step}, 32'd0);
    chk("reset_id_valid", {31'b0, id_valid}, 32'd0);
    chk("reset_id_instr", id_instr, NOP);
    chk("reset_id_pc", id_pc, 32'd0);
    chk("reset_id_fault", {31'b0, id_fault}, 32'd0);
    imem_req_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- directed table ----------------
    tbl[0]  = mk(32'h100, 0, 1, 0, 32'h0,        0, 0, 1, 1, 0, NOP,          32'h0,   0);
    tbl[1]  = mk(32'h104, 0, 1, 1, 32'h00500093, 0, 0, 0, 0, 0, NOP,          32'h0,   0);
    tbl[2]  = mk(32'h104, 0, 1, 0, 32'h0,        0, 0, 0, 0, 1, 32'h00500093, 32'h100, 0);
    tbl[3]  = mk(32'h104, 0, 1, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 32'h00500093, 32'h100, 0);
    tbl[4]  = mk(32'h104, 0, 1, 0, 32'h0,        0, 0, 0, 0, 1, 32'h00500093, 32'h100, 0);
    tbl[5]  = mk(32'h104, 0, 1, 0, 32'h0,        0, 0, 0, 0, 1, 32'h00500093, 32'h100, 0);
    tbl[6]  = mk(32'h104, 0, 1, 0, 32'h0,        0, 0, 0, 0, 1, 32'h00500093, 32'h100, 0);
    tbl[7]  = mk(32'h104, 0, 1, 0, 32'h0,        0, 1, 0, 0, 1, 32'h00500093, 32'h100, 0);
    tbl[8]  = mk(32'h104, 0, 1, 0, 32'h0,        0, 0, 1, 1, 0, 32'h00500093, 32'h100, 0);
    tbl[9]  = mk(32'h108, 1, 1, 0, 32'h0,        0, 0, 0, 0, 0, 32'h00500093, 32'h100, 0);
    tbl[10] = mk(32'h200, 0, 1, 0, 32'h0,        0, 0, 0, 0, 0, 32'h00500093, 32'h100, 0);
    tbl[11] = mk(32'h200, 0, 1, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 32'h00500093, 32'h100, 0);
    tbl[12] = mk(32'h200, 0, 1, 0, 32'h0,        0, 0, 1, 1, 0, 32'h00500093, 32'h100, 0);
    tbl[13] = mk(32'h204, 0, 1, 1, 32'h00A00113, 0, 0, 0, 0, 0, 32'h00500093, 32'h100, 0);
    tbl[14] = mk(32'h204, 0, 1, 0, 32'h0,        0, 1, 0, 0, 1, 32'h00A00113, 32'h200, 0);
    tbl[15] = mk(32'h102, 0, 1, 0, 32'h0,        0, 0, 0, 0, 0, 32'h00A00113, 32'h200, 0);
    tbl[16] = mk(32'h102, 0, 1, 0, 32'h0,        0, 0, 0, 0, 1, NOP,          32'h102, 1);
    tbl[17] = mk(32'h300, 1, 1, 0, 32'h0,        0, 0, 0, 0, 1, NOP,          32'h102, 1);
    tbl[18] = mk(32'h300, 0, 1, 0, 32'h0,        0, 0, 1, 1, 0, NOP,          32'h102, 1);
    tbl[19] = mk(32'h304, 0, 1, 1, 32'h12345678, 1, 0, 0, 0, 0, NOP,          32'h102, 1);
    tbl[20] = mk(32'h304, 0, 1, 0, 32'h0,        0, 1, 0, 0, 1, NOP,          32'h300, 1);
    tbl[21] = mk(32'h304, 0, 0, 0, 32'h0,        0, 0, 1, 0, 0, NOP,          32'h300, 1);
    tbl[22] = mk(32'h304, 1, 1, 0, 32'h0,        0, 0, 0, 0, 0, NOP,          32'h300, 1);

    for (int i = 0; i < 23; i++) begin
      @(posedge clk); #1;
      drive(tbl[i].pc, tbl[i].fl, tbl[i].rdy, tbl[i].rv, tbl[i].rd, tbl[i].re, tbl[i].idr);
      @(negedge clk);
      chk($sformatf("vec%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, tbl[i].e_rv});
      chk($sformatf("vec%0d_pc_step", i), {31'b0, pc_step}, {31'b0, tbl[i].e_step});
      chk($sformatf("vec%0d_id_valid", i), {31'b0, id_valid}, {31'b0, tbl[i].e_idv});
      chk($sformatf("vec%0d_id_instr", i), id_instr, tbl[i].e_instr);
      chk($sformatf("vec%0d_id_pc", i), id_pc, tbl[i].e_pc);
      chk($sformatf("vec%0d_id_fault", i), {31'b0, id_fault}, {31'b0, tbl[i].e_fault});
      if (tbl[i].e_rv) chk($sformatf("vec%0d_req_addr", i), imem_req_addr, tbl[i].pc);
    end

    // ---------------- stall then reset mid-WAIT ----------------
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(32'h304, 0, 0, 0, 32'h0, 0, 0);
      @(negedge clk);
      chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("stall_req_addr", imem_req_addr, 32'h304);
      chk("stall_pc_step", {31'b0, pc_step}, 32'd0);
    end
    @(posedge clk); #1;
    drive(32'h304, 0, 1, 0, 32'h0, 0, 0);
    @(negedge clk);
    chk("stall_accept_step", {31'b0, pc_step}, 32'd1);
    @(posedge clk); #1;
    drive(32'h308, 0, 0, 0, 32'h0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst6_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst6_pc_step", {31'b0, pc_step}, 32'd0);
    chk("rst6_id_valid", {31'b0, id_valid}, 32'd0);
    chk("rst6_id_instr", id_instr, NOP);
    chk("rst6_id_pc", id_pc, 32'd0);
    chk("rst6_id_fault", {31'b0, id_fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(32'h308, 0, 0, 1, 32'hDEADBEEF, 0, 0);
    @(negedge clk);
    chk("stray_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("stray_id_valid", {31'b0, id_valid}, 32'd0);
    @(posedge clk); #1;
    drive(32'h308, 0, 0, 0, 32'h0, 0, 0);
    @(negedge clk);
    chk("after_stray_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("after_stray_id_valid", {31'b0, id_valid}, 32'd0);
    chk("after_stray_id_instr", id_instr, NOP);

    // ---------------- randomized traffic vs transaction model ----------------
    begin
      logic [31:0] tpc, exp_pc, mem_addr, e_instr;
      logic        mem_busy, need_redirect, e_fault;
      int          mem_cnt, consumed;
      tpc = 32'h308; exp_pc = 32'h308; mem_addr = '0;
      mem_busy = 1'b0; need_redirect = 1'b0; mem_cnt = 0; consumed = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        @(posedge clk); #1;
        flush = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = $urandom;
        imem_rsp_err = 1'b0;
        if (need_redirect || $urandom_range(0, 99) < 4) begin
          flush = 1'b1;
          tpc = {20'h00001, 10'($urandom_range(0, 1023)), 2'b00};
          if (!need_redirect && $urandom_range(0, 9) == 0) tpc[1:0] = 2'($urandom_range(1, 3));
          exp_pc = tpc;
          need_redirect = 1'b0;
        end
        pc = tpc;
        if (mem_busy) begin
          if (mem_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data = mem_word(mem_addr);
            imem_rsp_err = mem_err(mem_addr);
            mem_busy = 1'b0;
          end else begin
            mem_cnt--;
          end
        end else if ($urandom_range(0, 99) < 8) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_err = 1'($urandom_range(0, 1));
        end
        imem_req_ready = ($urandom_range(0, 99) < 70);
        id_ready = ($urandom_range(0, 99) < 60);
        @(negedge clk);
        if (flush) chk("rnd_step_during_flush", {31'b0, pc_step}, 32'd0);
        if (tpc[1:0] != 2'b00) chk("rnd_req_on_misaligned", {31'b0, imem_req_valid}, 32'd0);
        if (imem_req_valid) chk("rnd_req_addr", imem_req_addr, tpc);
        chk("rnd_step_is_accept", {31'b0, pc_step}, {31'b0, imem_req_valid && imem_req_ready});
        if (imem_req_valid && imem_req_ready) begin
          mem_busy = 1'b1;
          mem_addr = tpc;
          mem_cnt = $urandom_range(0, 2);
        end
        if (pc_step) tpc = tpc + 32'd4;
        if (id_valid && id_ready && !flush) begin
          e_fault = (exp_pc[1:0] != 2'b00) || mem_err(exp_pc);
          e_instr = e_fault ? NOP : mem_word(exp_pc);
          chk("rnd_id_pc", id_pc, exp_pc);
          chk("rnd_id_instr", id_instr, e_instr);
          chk("rnd_id_fault", {31'b0, id_fault}, {31'b0, e_fault});
          consumed++;
          if (exp_pc[1:0] != 2'b00) need_redirect = 1'b1;
          else exp_pc = exp_pc + 32'd4;
        end
      end
      checks++;
      if (consumed < 100) begin
        errors++;
        $display("FAIL rnd_throughput actual=%0d required>=%0d", consumed, 100);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
